fetch_stage: RTL



---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and
// holds the IF/ID pipeline register, including stall, flush and redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        flush_D,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_f_r;
    logic [31:0] tgt_r;
    logic [31:0] hold_insn_r;
    logic [31:0] hold_pc_r;

    logic        load_s;
    logic [31:0] load_insn_s;
    logic [31:0] load_pc_s;

    // Request is a function of state only; rst masks it so no request leaks during reset.
    assign imem_req  = !rst && (state_r != ST_HOLD);
    assign imem_addr = pc_f_r;

    // Select what IF/ID would load this cycle if nothing higher-priority intervenes.
    always_comb begin
        load_s      = 1'b0;
        load_insn_s = hold_insn_r;
        load_pc_s   = hold_pc_r;
        case (state_r)
            ST_REQ: begin
                load_s      = imem_ack;
                load_insn_s = imem_rdata;
                load_pc_s   = pc_f_r;
            end
            ST_HOLD: begin
                load_s      = 1'b1;
                load_insn_s = hold_insn_r;
                load_pc_s   = hold_pc_r;
            end
            ST_DROP: begin
                load_s      = 1'b0;
                load_insn_s = hold_insn_r;
                load_pc_s   = hold_pc_r;
            end
            default: begin
                load_s      = 1'b0;
                load_insn_s = hold_insn_r;
                load_pc_s   = hold_pc_r;
            end
        endcase
    end

    // Fetch FSM, program counter, redirect target and one-entry hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_REQ;
            pc_f_r      <= RESET_PC;
            tgt_r       <= 32'h0000_0000;
            hold_insn_r <= 32'h0000_0000;
            hold_pc_r   <= 32'h0000_0000;
        end else if (redirect) begin
            hold_insn_r <= 32'h0000_0000;
            hold_pc_r   <= 32'h0000_0000;
            // An unacked request cannot be withdrawn: park the target and wait it out.
            if ((state_r != ST_HOLD) && !imem_ack) begin
                tgt_r   <= redirect_pc;
                state_r <= ST_DROP;
            end else begin
                pc_f_r  <= redirect_pc;
                state_r <= ST_REQ;
            end
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_f_r <= pc_f_r + 32'd4;
                        if (stall_F) begin
                            hold_insn_r <= imem_rdata;
                            hold_pc_r   <= pc_f_r;
                            state_r     <= ST_HOLD;
                        end else begin
                            state_r <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (stall_F) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        pc_f_r  <= tgt_r;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_REQ;
                end
            endcase
        end
    end

    // IF/ID register: redirect > flush > stall > load, otherwise a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_D <= NOP_INSN;
            pc_D    <= 32'h0000_0000;
            pc4_D   <= 32'h0000_0004;
            valid_D <= 1'b0;
        end else if (redirect || flush_D) begin
            instr_D <= NOP_INSN;
            valid_D <= 1'b0;
        end else if (stall_F) begin
            instr_D <= instr_D;
            valid_D <= valid_D;
        end else if (load_s) begin
            instr_D <= load_insn_s;
            pc_D    <= load_pc_s;
            pc4_D   <= load_pc_s + 32'd4;
            valid_D <= 1'b1;
        end else begin
            instr_D <= NOP_INSN;
            valid_D <= 1'b0;
        end
    end

endmodule
